piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Drives a serial bit stream with framing strobes (first/last).
- Pairs with the team's serial-in capture logic as the transmit end of the same single-wire bit link.

Parameters:
- WIDTH, 8, data word width in bits; legal range is WIDTH >= 2.
- LSB_FIRST, 0, bit order: 0 sends MSB first, 1 sends LSB first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word; sampled only on accept.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_first  output  1  first bit of a frame.
- ser_last  output  1  final bit of a frame (the parity bit when parity is enabled).
- busy  output  1  frame in progress; equals ser_valid.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high: it is sampled only on the rising edge of clk. Ports are named clk and rst.
- Reset values: ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, shift register=0, bit counter=0, state=IDLE.
- in_ready is combinational: in_ready = !rst && (state==IDLE || ser_last).
- Accept happens on a rising edge where in_valid && in_ready.
  - in_data is captured into the shift register.
  - The counter loads with the frame length: FLEN = WIDTH, or WIDTH+1 when parity is enabled.
- States:
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT on accept during the ser_last cycle (back-to-back frames).
  - SHIFT -> IDLE after the ser_last cycle when there is no accept.
- All serial outputs are registered. Latency: the first bit is presented in the cycle after the accepting edge.
  - ser_valid stays high for exactly FLEN consecutive cycles.
  - ser_first is high in the first of those cycles only.
  - ser_last is high in the final cycle only.
- Bit order:
  - LSB_FIRST=0: in_data[WIDTH-1] first, down to in_data[0].
  - LSB_FIRST=1: in_data[0] first, up to in_data[WIDTH-1].
- Back-to-back accept: accepting during the ser_last cycle makes the next frame's first bit follow with zero gap. ser_first and ser_valid are both high on that next cycle.
- No output backpressure: a frame, once started, always completes.
- Upstream rules:
  - in_valid while in_ready=0 is ignored.
  - Upstream must hold in_data stable until accept.
- When ser_valid=0, ser_out is driven 0.
- Reset mid-frame: at the next rising edge with rst=1, the frame is abandoned and all outputs return to reset values in that cycle. in_ready=0 while rst=1 and returns to 1 in the first cycle with rst=0.
- Counter width is $clog2(WIDTH+2). No wrap-around: the counter never underflows below 0 in IDLE.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined: FLEN = WIDTH+1. After the last data bit, one even-parity bit (^in_data of the accepted word) is sent; ser_last marks the parity bit.
- Undefined: FLEN = WIDTH, no parity logic exists, and ser_last marks the last data bit.

Decomposition:
- Shared package (piso_pkg) holds:
  - state encoding constants: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - the FLEN computation as a localparam/function of WIDTH and the macro.
- One natural sub-module, bit_down_counter: loadable down-counter with a synchronous active-high reset, a zero flag and a last flag (count==1). It is instantiated once.
- Shift register and handshake logic stay in the top module.

Test Plan:
- WIDTH=8, LSB_FIRST=0. Send 0xC1 with in_valid for one cycle while idle -> ser_out=1,1,0,0,0,0,0,1 over 8 cycles starting the cycle after accept; ser_first on bit 1, ser_last on bit 8, then ser_valid=0 and in_ready=1.
- LSB_FIRST=1. Send 0xC1 -> ser_out=1,0,0,0,0,0,1,1.
- Back-to-back: hold in_valid with 0x0F then 0xF0 -> 16 contiguous ser_valid cycles, ser_out=00001111 11110000, ser_first at cycles 1 and 9, ser_last at cycles 8 and 16.
- Busy rejection: pulse in_valid with 0xFF at bit 3 of a 0x00 frame -> in_ready=0, word ignored, output stays all zeros, no second frame.
- Reset mid-frame: assert rst during bit 4 of 0xAA -> next cycle all outputs 0; after rst drops, in_ready=1 and a fresh 0x81 serializes correctly.
- With PISO_SERIALIZER_PARITY_EN: send 0xC1 -> 9 bits 1,1,0,0,0,0,0,1,1; ser_last on the 9th bit (parity=1). Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: state encoding and frame length.
// Frame length grows by one parity bit when PISO_SERIALIZER_PARITY_EN is defined.
package piso_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int flen(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction
endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter that saturates at zero; flags zero and one-remaining.
module bit_down_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          zero,
  output logic          last
);
  always_ff @(posedge clk) begin
    if (rst)                  count <= '0;
    else if (load)            count <= load_val;
    else if (dec && !zero)    count <= count - 1'b1;
  end

  assign zero = (count == '0);
  assign last = (count == CW'(1));
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with first/last framing strobes.
// Optional even-parity trailer bit enabled by PISO_SERIALIZER_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);
  localparam int FLEN = flen(WIDTH);
  localparam int CW   = $clog2(WIDTH + 2);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] load_rest, shreg_nxt;
  logic             first_bit, head, next_bit, accept;
  logic [CW-1:0]    cnt;
  logic             cnt_zero, cnt_last;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par;
`endif

  assign in_ready = !rst && (state == ST_IDLE || ser_last);
  assign accept   = in_valid && in_ready;
  assign busy     = ser_valid;

  // Counter holds bits remaining including the one currently on ser_out.
  bit_down_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .dec      (state == ST_SHIFT && !accept && !cnt_zero),
    .load_val (CW'(FLEN)),
    .count    (cnt),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  assign first_bit = LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
  assign load_rest = LSB_FIRST ? {1'b0, in_data[WIDTH-1:1]} : {in_data[WIDTH-2:0], 1'b0};
  assign head      = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  assign shreg_nxt = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
`ifdef PISO_SERIALIZER_PARITY_EN
  // Two remaining means the bit about to go out is the parity trailer.
  assign next_bit  = (cnt == CW'(2)) ? par : head;
`else
  assign next_bit  = head;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (accept) begin
      state     <= ST_SHIFT;
      shreg     <= load_rest;
      ser_out   <= first_bit;
      ser_valid <= 1'b1;
      ser_first <= 1'b1;
      ser_last  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par       <= ^in_data;
`endif
    end else if (state == ST_SHIFT) begin
      if (cnt_last) begin
        state     <= ST_IDLE;
        ser_out   <= 1'b0;
        ser_valid <= 1'b0;
        ser_first <= 1'b0;
        ser_last  <= 1'b0;
      end else begin
        shreg     <= shreg_nxt;
        ser_out   <= next_bit;
        ser_first <= 1'b0;
        ser_last  <= (cnt == CW'(2));
      end
    end
  end
endmodule
